// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues word fetches over req/ack and buffers {pc, inst}
// in a small FIFO whose head feeds the IF/ID register; redirects flush and refetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         PW       = $clog2(DEPTH),
    localparam int         CW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [31:0]   redirectPc,
    input  logic          deqEn,
    output logic          memReq,
    output logic [31:0]   memAddr,
    input  logic          memAck,
    input  logic [31:0]   memData,
    output logic          instValid,
    output logic [31:0]   instOut,
    output logic [31:0]   instPc,
    output logic [31:0]   instPcPlus4,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t                  state_q;
    logic [31:0]             fetchPc_q, pendingPc_q;
    logic [DEPTH-1:0][31:0]  pcs_q, insts_q;
    logic [PW-1:0]           head_q, tail_q, head_d, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    enq, deq;

    // A redirect cancels both the write and the dequeue of its cycle.
    always_comb begin
        deq     = deqEn && (count_q != '0) && !redirect;
        enq     = (state_q == FETCH) && memAck && !redirect;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq) head_d = head_q + PW'(1);
            if (enq) tail_d = tail_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetchPc_q   <= RESET_PC;
            pendingPc_q <= '0;
            pcs_q       <= '0;
            insts_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                pcs_q[tail_q]   <= fetchPc_q;
                insts_q[tail_q] <= memData;
            end
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetchPc_q <= redirectPc;
                        state_q   <= FETCH;
                    end else if (count_q < CW'(DEPTH)) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (memAck && !redirect) begin
                        fetchPc_q <= fetchPc_q + 32'd4;
                        if (count_d == CW'(DEPTH)) state_q <= IDLE;
                    end else if (memAck && redirect) begin
                        fetchPc_q <= redirectPc;
                    end else if (redirect) begin
                        // Address must stay stable until the old request is acked.
                        pendingPc_q <= redirectPc;
                        state_q     <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (redirect) pendingPc_q <= redirectPc;
                    if (memAck) begin
                        fetchPc_q <= redirect ? redirectPc : pendingPc_q;
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memReq      = (state_q != IDLE);
    assign memAddr     = fetchPc_q;
    assign instValid   = (count_q != '0);
    assign instOut     = insts_q[head_q];
    assign instPc      = pcs_q[head_q];
    assign instPcPlus4 = pcs_q[head_q] + 32'd4;
    assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random stimulus for fetch_queue, checked against a queue-based
// reference model of the prefetcher.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        redirect = 1'b0, deqEn = 1'b0, memAck = 1'b0;
    logic [31:0] redirectPc = '0, memData = '0;
    logic        memReq, instValid;
    logic [31:0] memAddr, instOut, instPc, instPcPlus4;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirectPc(redirectPc),
        .deqEn(deqEn), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
        .memData(memData), .instValid(instValid), .instOut(instOut),
        .instPc(instPc), .instPcPlus4(instPcPlus4), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          m_busy, m_drop;
    logic [31:0] m_addr, m_pend;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_drop = 0;
        m_addr = 32'h0;
        m_pend = 32'h0;
    endtask

    task automatic check_reset();
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_instValid", 32'(instValid), 32'd0);
        chk("rst_instOut", instOut, 32'h0);
        chk("rst_instPc", instPc, 32'h0);
        chk("rst_instPcPlus4", instPcPlus4, 32'h4);
        chk("rst_count", 32'(count), 32'd0);
    endtask

    task automatic check_all();
        chk("memReq", 32'(memReq), 32'(m_busy));
        if (m_busy) chk("memAddr", memAddr, m_addr);
        chk("instValid", 32'(instValid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        if (q.size() != 0) begin
            chk("instOut", instOut, q[0].inst);
            chk("instPc", instPc, q[0].pc);
            chk("instPcPlus4", instPcPlus4, q[0].pc + 32'd4);
        end
    endtask

    // One clock edge of the reference prefetcher, using the currently driven inputs.
    task automatic model_step();
        int old_size = q.size();
        if (redirect) q.delete();
        else if (deqEn && q.size() > 0) void'(q.pop_front());
        if (!m_busy) begin
            if (redirect) begin
                m_addr = redirectPc;
                m_busy = 1;
            end else if (old_size < DEPTH) m_busy = 1;
        end else if (!m_drop) begin
            if (memAck && !redirect) begin
                q.push_back('{pc: m_addr, inst: memData});
                m_addr = m_addr + 32'd4;
                if (q.size() == DEPTH) m_busy = 0;
            end else if (memAck) begin
                m_addr = redirectPc;
            end else if (redirect) begin
                m_pend = redirectPc;
                m_drop = 1;
            end
        end else begin
            if (redirect) m_pend = redirectPc;
            if (memAck) begin
                m_addr = redirect ? redirectPc : m_pend;
                m_drop = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input logic [31:0] rpc, input bit d, input bit a);
        redirect   = r;
        redirectPc = rpc;
        deqEn      = d;
        memAck     = a && m_busy;
        memData    = $urandom;
        model_step();
        @(posedge clk);
        #1 check_all();
    endtask

    initial begin
        model_reset();
        #2 check_reset();
        @(negedge clk) rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("first_req", 32'(memReq), 32'd1);
        chk("first_addr", memAddr, 32'h0);

        // streaming: ack tied to request, continuous dequeue
        repeat (12) cyc(0, 0, 1, 1);

        // full backpressure from a clean queue at address 0
        cyc(1, 32'h0, 0, 1);
        repeat (6) cyc(0, 0, 0, 1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_memReq", 32'(memReq), 32'd0);
        cyc(0, 0, 1, 0);
        chk("deq_count", 32'(count), 32'd3);
        cyc(0, 0, 0, 0);
        chk("refetch_req", 32'(memReq), 32'd1);
        chk("refetch_addr", memAddr, 32'd16);

        // refill, then redirect while idle and full
        cyc(0, 0, 0, 1);
        chk("refull_req", 32'(memReq), 32'd0);
        cyc(1, 32'h20, 0, 0);
        chk("idle_redir_count", 32'(count), 32'd0);
        chk("idle_redir_addr", memAddr, 32'h20);

        // redirect with the request at 0x20 still outstanding
        cyc(0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0);
        chk("pend_count", 32'(count), 32'd0);
        cyc(0, 0, 0, 0);
        chk("pend_addr_hold", memAddr, 32'h20);
        cyc(0, 0, 0, 1);
        chk("pend_count_after_ack", 32'(count), 32'd0);
        chk("pend_next_addr", memAddr, 32'h100);
        cyc(0, 0, 0, 1);
        chk("pend_first_pc", instPc, 32'h100);

        // redirect coinciding with ack, landing at the top of the address space
        cyc(1, 32'hFFFF_FFFC, 0, 1);
        chk("same_cycle_count", 32'(count), 32'd0);
        chk("same_cycle_addr", memAddr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        chk("wrap_addr", memAddr, 32'h0);
        chk("wrap_plus4", instPcPlus4, 32'h0);

        // dequeue on an empty queue
        cyc(1, 32'h40, 0, 0);
        cyc(0, 0, 1, 0);
        chk("deq_empty_count", 32'(count), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            cyc($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 6);
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1 check_reset();
                model_reset();
                #1 rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between a multi-cycle instruction memory and the IF stage of the 5-stage MIPS pipeline. It issues word fetches over a req/ack handshake and buffers returned instructions with their PCs in a small FIFO. It presents the head entry to the IF/ID register. Branch and jump redirects from ID flush the queue and restart fetching at the target.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `redirect`  in  1: taken branch or jump; flush and refetch from `redirectPc`.
- `redirectPc`  in  32: target address; sampled only when `redirect` is 1.
- `deqEn`  in  1: IF consumes the head entry (driven by pcWrite); ignored when empty or when `redirect` is 1.
- `memReq`  out  1: fetch request.
- `memAddr`  out  32: fetch address; held stable while `memReq` is 1 and `memAck` is 0.
- `memAck`  in  1: memory completes the request this cycle.
- `memData`  in  32: instruction word; valid only when `memAck` is 1.
- `instValid`  out  1: head entry valid (count != 0).
- `instOut`  out  32: head instruction.
- `instPc`  out  32: head instruction address.
- `instPcPlus4`  out  32: `instPc` + 4, modulo 2^32.
- `count`  out  $clog2(DEPTH)+1: occupancy.

## Operation
- Registers:
  - `fetchPc`, the address of the current or next request.
  - `pendingPc`, the redirect target held during DISCARD.
  - FIFO storage of {pc, inst} with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: `memReq`=0. Go to FETCH when count < DEPTH or `redirect`=1. On redirect: `fetchPc`<=`redirectPc`.
  - FETCH: `memReq`=1, `memAddr`=`fetchPc`. FETCH is entered only with at least one free slot, so one outstanding request is the maximum.
    - `memAck`=1, no redirect: write {`fetchPc`, `memData`} at the tail; `fetchPc`<=`fetchPc`+4. Go to IDLE if the resulting count == DEPTH, otherwise stay in FETCH.
    - `memAck`=1 with `redirect`=1: drop `memData`; `fetchPc`<=`redirectPc`; stay in FETCH.
    - `memAck`=0 with `redirect`=1: `pendingPc`<=`redirectPc`; go to DISCARD.
  - DISCARD: `memReq`=1, `memAddr`=`fetchPc` (the old address, kept stable).
    - Each further `redirect` overwrites `pendingPc`.
    - On `memAck`: drop data; `fetchPc`<=`pendingPc`, or `redirectPc` if `redirect`=1 in the same cycle; go to FETCH.
- Flush: `redirect`=1 sets count, head and tail to 0 at that edge. No write and no dequeue occur that cycle.
- Dequeue: `deqEn`=1 with count > 0 and no redirect advances head.
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance. This is legal at count == DEPTH only in the sense that an ack cannot occur when full, since FETCH is never held while full.
- Resulting count uses the post-dequeue value. Enqueue with dequeue at count == DEPTH-1 stays in FETCH.
- PC arithmetic is 32-bit and wraps at 2^32 with no fault. Low two PC bits are not checked.

## Timing
- Reset (async, immediate):
  - state=IDLE, `fetchPc`=`RESET_PC`, `pendingPc`=0, count=0.
  - `memReq`=0, `memAddr`=`RESET_PC`.
  - `instValid`=0, `instOut`=0, `instPc`=0, `instPcPlus4`=4.
  - Storage cleared to 0.
- First `memReq` appears the first cycle after `rst` deasserts.
- Latency:
  - Ack at edge N makes the entry visible on `instValid` and `instOut` after edge N; there is no combinational bypass.
  - With single-cycle ack and continuous `deqEn`, throughput is 1 instruction per cycle.
- Outputs:
  - Head outputs are registered-state driven and stable between edges.
  - `memReq` and `memAddr` are decoded from state and `fetchPc` only. Neither depends combinationally on `memAck`, `redirect` or `deqEn`.
- Reset mid-request: the request is abandoned. Memory must tolerate `memReq` dropping without ack on reset.

## Test plan
- **Reset:** assert `rst` mid-operation → all outputs at the reset values above immediately. After release, `memReq`=1 with `memAddr`=0 one cycle later.
- **Streaming:** `memAck` tied to `memReq`, `deqEn`=1 → `instPc` sequence 0,4,8,12,… one per cycle. `instPcPlus4` always equals `instPc`+4.
- **Full backpressure:** DEPTH=4, `deqEn`=0, immediate ack → count reaches 4 and `memReq` drops to 0. One `deqEn` pulse → count 3, then `memReq`=1 next cycle at address 16.
- **Redirect during a pending request:** request at 0x20 with ack delayed 3 cycles, `redirect` to 0x100 → count 0 immediately. `memAddr` stays at 0x20 until ack and that data never enters the queue. The next request is at 0x100.
- **Redirect with ack in the same cycle:** → data dropped, next `memAddr`=target, count 0.
- **Boundary cases:**
  - `deqEn` on an empty queue → no change.
  - `redirect` in IDLE with a full queue → flush, FETCH at target.
  - `fetchPc`=0xFFFFFFFC followed by ack → next address is 0x00000000.
